serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/full_sub.sv | 13 +
 rtl/serial_sub.sv | 105 ++++++++++
 tb/tb_serial_sub.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The optional overflow output is enabled with SERIAL_SUB_OVF_EN (see serial_sub.sv).
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/full_sub.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bo = borrow out.
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one result bit per cycle, LSB first, valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output 'ovf'.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             bit_d;
  logic             bit_bo;
  logic             accept;
  logic             last_bit;

  full_sub u_full_sub (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .bin (borrow),
    .d   (bit_d),
    .bo  (bit_bo)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);
  assign last_bit  = (cnt == LAST_BIT);
  assign bout      = borrow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands shift right so bit 0 is always the current bit; results enter diff at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      diff   <= {bit_d, diff[WIDTH-1:1]};
      borrow <= bit_bo;
      if (!last_bit) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // On the last bit the shift registers hold the operand sign bits and bit_d is the result sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if ((state == BUSY) && last_bit) begin
      ovf <= (a_sh[0] ^ b_sh[0]) & (bit_d ^ a_sh[0]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: arithmetic reference model plus directed vectors.
module tb_serial_sub;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  diff;
  logic          bout;
`ifdef SERIAL_SUB_OVF_EN
  logic          ovf;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            in_flight = 1'b0;
  int            cyc = 0;
  logic [W:0]    exp_full;
  logic          exp_ovf;

  serial_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Model: a result appears WIDTH edges after acceptance and stays until taken.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_flight = 1'b0;
      cyc = 0;
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_diff", 64'(diff), 64'd0);
      checkOutput("rst_bout", 64'(bout), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
      checkOutput("rst_ovf", 64'(ovf), 64'd0);
`endif
    end else begin
      checkOutput("m_out_valid", 64'(out_valid), 64'(in_flight && cyc >= W));
      checkOutput("m_in_ready", 64'(in_ready), 64'(!in_flight));
      if (in_flight && cyc >= W) begin
        checkOutput("m_diff", 64'(diff), 64'(exp_full[W-1:0]));
        checkOutput("m_bout", 64'(bout), 64'(exp_full[W]));
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("m_ovf", 64'(ovf), 64'(exp_ovf));
`endif
      end
      if (!in_flight) begin
        if (in_valid) begin
          in_flight = 1'b1;
          cyc = 0;
          exp_full = {1'b0, a} - {1'b0, b};
          exp_ovf = (a[W-1] != b[W-1]) && (exp_full[W-1] != a[W-1]);
        end
      end else if (cyc >= W) begin
        if (out_ready) in_flight = 1'b0;
      end else begin
        cyc++;
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic waitResult(input string name, input logic [W-1:0] ed, input logic eb,
                            input logic eo, input int hold);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({name, "_latency"}, 64'(n), 64'(W));
    checkOutput({name, "_diff"}, 64'(diff), 64'(ed));
    checkOutput({name, "_bout"}, 64'(bout), 64'(eb));
`ifdef SERIAL_SUB_OVF_EN
    checkOutput({name, "_ovf"}, 64'(ovf), 64'(eo));
`else
    if (eo === 1'bx) $display("[TB] note: unknown ovf expectation for %s", name);
`endif
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      checkOutput({name, "_hold_diff"}, 64'(diff), 64'(ed));
      checkOutput({name, "_hold_bout"}, 64'(bout), 64'(eb));
      checkOutput({name, "_hold_ready"}, 64'({in_ready, out_valid}), 64'b01);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({name, "_release"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W:0] e;
    logic [W-1:0] av;
    logic [W-1:0] bv;

    #1 rst_n = 1'b0;
    #1;
    checkOutput("por_in_ready", 64'(in_ready), 64'd1);
    checkOutput("por_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(32'd5, 32'd3);
    waitResult("sub_5_3", 32'd2, 1'b0, 1'b0, 0);

    applyStimulus(32'd0, 32'd1);
    waitResult("sub_0_1", 32'hFFFF_FFFF, 1'b1, 1'b0, 0);

    applyStimulus(32'h8000_0000, 32'd1);
    waitResult("sub_min_1", 32'h7FFF_FFFF, 1'b0, 1'b1, 0);

    applyStimulus(32'h1234_5678, 32'h0FED_CBA9);
    waitResult("backpressure", 32'h0246_8ACF, 1'b0, 1'b0, 10);

    for (int i = 0; i < W; i++) begin
      av = 32'h1 << i;
      bv = 32'h1 << ((i * 7 + 3) % W);
      e = {1'b0, av} - {1'b0, bv};
      applyStimulus(av, bv);
      waitResult("walk", e[W-1:0], e[W], (av[W-1] != bv[W-1]) && (e[W-1] != av[W-1]), 0);
    end

    applyStimulus(32'hFFFF_FFFF, 32'd0);
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_diff", 64'(diff), 64'd0);
    checkOutput("abort_bout", 64'(bout), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_valid", 64'(out_valid), 64'd0);
    end

    applyStimulus(32'd3, 32'd5);
    waitResult("sub_3_5", 32'hFFFF_FFFE, 1'b1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
